// File: rtl/mux2_1_rr_arbiter_pkg.sv
// mux_arb_pkg: shared state encoding, lane ids and default sizes for the 2:1 round-robin mux
package mux_arb_pkg;
  typedef enum logic [1:0] {IDLE, SERVE0, SERVE1} state_t;
  localparam logic LANE0 = 1'b0;
  localparam logic LANE1 = 1'b1;
  localparam int DEF_DATA_W = 2;
  localparam int DEF_MAX_BURST = 4;
endpackage

// File: rtl/mux2_1_rr_arbiter_if.sv
// mux2_1_rr_arbiter_if: two valid/ready request lanes plus the shared registered output channel
interface mux2_1_rr_arbiter_if import mux_arb_pkg::*; #(parameter int DATA_W = DEF_DATA_W);
  logic valid0, ready0, valid1, ready1, out_valid, out_ready, lane_out;
  logic [DATA_W-1:0] data_in0, data_in1, data_out;
  modport master (
    output valid0, data_in0, valid1, data_in1, out_ready,
    input ready0, ready1, out_valid, data_out, lane_out
  );
  modport slave (
    input valid0, data_in0, valid1, data_in1, out_ready,
    output ready0, ready1, out_valid, data_out, lane_out
  );
endinterface

// File: rtl/mux2_1_rr_arbiter_outreg.sv
// mux_arb_outreg: one-entry output register; holds its word until downstream takes it
module mux_arb_outreg import mux_arb_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              lane,
  input  logic [DATA_W-1:0] data,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] data_out,
  output logic              lane_out,
  output logic              can_accept
);
  assign can_accept = !out_valid || out_ready;
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      data_out  <= '0;
      lane_out  <= LANE0;
    end else if (load) begin
      out_valid <= 1'b1;
      data_out  <= data;
      lane_out  <= lane;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/mux2_1_rr_arbiter.sv
// mux2_1_rr_arbiter: round-robin 2:1 mux with bounded bursts feeding a registered output channel
module mux2_1_rr_arbiter import mux_arb_pkg::*; #(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input logic                clk,
  input logic                reset,
  mux2_1_rr_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);
  state_t state, state_nxt;
  logic [CNT_W-1:0] burst_cnt, cnt_nxt;
  logic last_lane, can_accept, expired, pick1, g1, load, lane_sel, same_lane, idle_go;
  logic [DATA_W-1:0] data_sel;
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      burst_cnt <= '0;
      last_lane <= LANE1;
    end else begin
      state     <= state_nxt;
      burst_cnt <= cnt_nxt;
      if (load) last_lane <= lane_sel;
    end
  end
  // burst_cnt saturates at MAX_CNT, so "expired" stays true until the other lane wins
  always_comb begin
    expired   = burst_cnt >= MAX_CNT;
    idle_go   = can_accept && !bus.valid0 && !bus.valid1;
    same_lane = lane_sel ? (state == SERVE1) : (state == SERVE0);
    state_nxt = load ? (lane_sel ? SERVE1 : SERVE0) : idle_go ? IDLE : state;
    cnt_nxt   = load ? (same_lane ? (expired ? MAX_CNT : burst_cnt + 1'b1) : CNT_W'(1))
              : idle_go ? '0 : burst_cnt;
  end
  always_comb begin
    pick1      = (state == IDLE) ? (last_lane == LANE0) : (state == SERVE1) ? !expired : expired;
    g1         = bus.valid1 && (!bus.valid0 || pick1);
    bus.ready1 = !reset && can_accept && g1;
    bus.ready0 = !reset && can_accept && bus.valid0 && !g1;
    load       = bus.ready0 || bus.ready1;
    lane_sel   = bus.ready1 ? LANE1 : LANE0;
    data_sel   = bus.ready1 ? bus.data_in1 : bus.data_in0;
  end
  mux_arb_outreg #(.DATA_W(DATA_W)) u_outreg (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .lane       (lane_sel),
    .data       (data_sel),
    .out_ready  (bus.out_ready),
    .out_valid  (bus.out_valid),
    .data_out   (bus.data_out),
    .lane_out   (bus.lane_out),
    .can_accept (can_accept)
  );
endmodule

// File: tb/tb_mux2_1_rr_arbiter.sv
// tb_mux2_1_rr_arbiter: directed vectors with hand-computed expectations for the round-robin mux
module tb_mux2_1_rr_arbiter;
  import mux_arb_pkg::*;
  logic clk = 1'b0;
  logic reset;
  int n_checks = 0;
  int n_fail = 0;
  int exp_lane [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
  mux2_1_rr_arbiter_if #(.DATA_W(2)) bus ();
  mux2_1_rr_arbiter #(.DATA_W(2), .MAX_BURST(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check_ready(input string tag, input int r0, input int r1);
    #1;
    check({tag, "_ready0"}, int'(bus.ready0), r0);
    check({tag, "_ready1"}, int'(bus.ready1), r1);
  endtask
  initial begin
    reset = 1'b1;
    bus.valid0 = 1'b1;
    bus.valid1 = 1'b1;
    bus.data_in0 = 2'b01;
    bus.data_in1 = 2'b10;
    bus.out_ready = 1'b1;
    tick();
    check_ready("rst", 0, 0);
    tick();
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_data_out", int'(bus.data_out), 0);
    check("rst_lane_out", int'(bus.lane_out), 0);
    check("rst_state", int'(dut.state), int'(IDLE));
    check("rst_burst", int'(dut.burst_cnt), 0);
    reset = 1'b0;
    for (int k = 0; k < 9; k++) begin
      check_ready($sformatf("cont%0d", k), int'(exp_lane[k] == 0), int'(exp_lane[k] == 1));
      tick();
      check($sformatf("cont%0d_lane", k), int'(bus.lane_out), exp_lane[k]);
      check($sformatf("cont%0d_data", k), int'(bus.data_out), exp_lane[k] ? 2 : 1);
      check($sformatf("cont%0d_valid", k), int'(bus.out_valid), 1);
    end
    bus.valid0 = 1'b0;
    bus.valid1 = 1'b0;
    check_ready("drain", 0, 0);
    tick();
    check("drain_out_valid", int'(bus.out_valid), 0);
    check("drain_state", int'(dut.state), int'(IDLE));
    check("drain_burst", int'(dut.burst_cnt), 0);
    bus.valid0 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.data_in0 = 2'(k);
      check_ready($sformatf("single%0d", k), 1, 0);
      tick();
      check($sformatf("single%0d_data", k), int'(bus.data_out), k);
      check($sformatf("single%0d_lane", k), int'(bus.lane_out), 0);
    end
    check("single_burst", int'(dut.burst_cnt), 4);
    bus.out_ready = 1'b0;
    bus.valid1 = 1'b1;
    bus.data_in0 = 2'b01;
    bus.data_in1 = 2'b10;
    for (int k = 0; k < 3; k++) begin
      check_ready($sformatf("stall%0d", k), 0, 0);
      tick();
      check($sformatf("stall%0d_data", k), int'(bus.data_out), 3);
      check($sformatf("stall%0d_valid", k), int'(bus.out_valid), 1);
      check($sformatf("stall%0d_burst", k), int'(dut.burst_cnt), 4);
    end
    bus.out_ready = 1'b1;
    check_ready("unstall", 0, 1);
    tick();
    check("unstall_data", int'(bus.data_out), 2);
    check("unstall_lane", int'(bus.lane_out), 1);
    check("unstall_burst", int'(dut.burst_cnt), 1);
    check("unstall_state", int'(dut.state), int'(SERVE1));
    bus.valid1 = 1'b0;
    for (int k = 0; k < 2; k++) begin
      check_ready($sformatf("lane0_%0d", k), 1, 0);
      tick();
    end
    check("lane0_burst", int'(dut.burst_cnt), 2);
    check("lane0_state", int'(dut.state), int'(SERVE0));
    bus.valid0 = 1'b0;
    bus.valid1 = 1'b1;
    bus.data_in1 = 2'b11;
    check_ready("release", 0, 1);
    tick();
    check("release_burst", int'(dut.burst_cnt), 1);
    check("release_state", int'(dut.state), int'(SERVE1));
    check("release_data", int'(bus.data_out), 3);
    check("release_lane", int'(bus.lane_out), 1);
    bus.valid1 = 1'b0;
    tick();
    check("idle_state", int'(dut.state), int'(IDLE));
    check("idle_burst", int'(dut.burst_cnt), 0);
    check("idle_out_valid", int'(bus.out_valid), 0);
    bus.valid0 = 1'b1;
    bus.valid1 = 1'b1;
    check_ready("tie", 1, 0);
    tick();
    check("tie_lane", int'(bus.lane_out), 0);
    check("tie_data", int'(bus.data_out), 1);
    tick();
    tick();
    check("pre_rst_burst", int'(dut.burst_cnt), 3);
    check("pre_rst_state", int'(dut.state), int'(SERVE0));
    check("pre_rst_valid", int'(bus.out_valid), 1);
    reset = 1'b1;
    check_ready("mid_rst", 0, 0);
    tick();
    check("mid_rst_valid", int'(bus.out_valid), 0);
    check("mid_rst_burst", int'(dut.burst_cnt), 0);
    check("mid_rst_state", int'(dut.state), int'(IDLE));
    check("mid_rst_data", int'(bus.data_out), 0);
    reset = 1'b0;
    check_ready("post_rst", 1, 0);
    tick();
    check("post_rst_lane", int'(bus.lane_out), 0);
    check("post_rst_valid", int'(bus.out_valid), 1);
    bus.valid0 = 1'b0;
    bus.valid1 = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    check("hold_valid", int'(bus.out_valid), 1);
    check("hold_data", int'(bus.data_out), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
